sample2uart: RTL

- Serializes 16-bit samples into pairs of 8-bit UART frames for the UART transmitter; this is the transmit-side counterpart of the sample assembler.
- Samples are buffered in a small FIFO and sent low byte first, then high byte, matching the receive-side assembly order ([7:0] then [15:8]).
- Sits between the sample source (DSP/filter output) and the UART TX byte interface.

---
 rtl/sample2uart_pkg.sv | 24 ++
 rtl/sample2uart_sample_fifo.sv | 53 +++++
 rtl/sample2uart.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sample2uart_pkg.sv
// rtl/sample2uart_pkg.sv - shared widths, FSM state type and byte-order helpers for sample2uart
package sample2uart_pkg;

    localparam int SAMPLE_W = 16;
    localparam int BYTE_W   = 8;

    // Shared with the receive-side assembler so both ends agree on wire order.
    localparam bit LOW_BYTE_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } state_t;

    function automatic logic [BYTE_W-1:0] first_byte(input logic [SAMPLE_W-1:0] s);
        return LOW_BYTE_FIRST ? s[BYTE_W-1:0] : s[SAMPLE_W-1:BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] second_byte(input logic [SAMPLE_W-1:0] s);
        return LOW_BYTE_FIRST ? s[SAMPLE_W-1:BYTE_W] : s[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/sample2uart_sample_fifo.sv
// rtl/sample2uart_sample_fifo.sv - synchronous FIFO with registered count and full/empty flags
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_push,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_pop,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_full,
    output logic                     out_empty,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign out_full  = (r_count == CNT_W'(DEPTH));
    assign out_empty = (r_count == '0);
    assign out_count = r_count;
    assign out_data  = r_mem[r_rd_ptr];

    assign w_do_push = in_push && !out_full;
    assign w_do_pop  = in_pop && !out_empty;

    // Pointers are exactly PTR_W bits, so wrap-around is the natural overflow.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

// File: rtl/sample2uart.sv
// rtl/sample2uart.sv - buffers 16-bit samples and serializes each into two UART byte frames
module sample2uart
    import sample2uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_sample_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                out_sample_ready,
    output logic [BYTE_W-1:0]   out_uart_frame,
    output logic                out_uart_valid,
    input  logic                in_uart_ready,
    output logic                out_overflow,
    output logic                out_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_xfer;

    state_t              r_state, w_state_nxt;
    logic [SAMPLE_W-1:0] r_hold, w_hold_nxt;
    logic [BYTE_W-1:0]   r_frame, w_frame_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_overflow;

    assign w_push = in_sample_valid && !w_full;
    assign w_xfer = r_valid && in_uart_ready;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_push   (w_push),
        .in_data   (in_sample),
        .in_pop    (w_pop),
        .out_data  (w_head),
        .out_full  (w_full),
        .out_empty (w_empty),
        .out_count (w_count)
    );

    // SEND_LO entered from IDLE spends one cycle loading the frame; a
    // back-to-back entry from SEND_HI already has the frame loaded.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_frame_nxt = r_frame;
        w_valid_nxt = r_valid;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = w_head;
                    w_state_nxt = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (!r_valid) begin
                    w_valid_nxt = 1'b1;
                    w_frame_nxt = first_byte(r_hold);
                end else if (w_xfer) begin
                    w_frame_nxt = second_byte(r_hold);
                    w_state_nxt = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (w_xfer) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_hold_nxt  = w_head;
                        w_frame_nxt = first_byte(w_head);
                        w_state_nxt = ST_SEND_LO;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_frame    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_frame    <= w_frame_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= in_sample_valid && w_full;
        end
    end

    assign out_sample_ready = !w_full;
    assign out_uart_frame   = r_frame;
    assign out_uart_valid   = r_valid;
    assign out_overflow     = r_overflow;
    assign out_busy         = (r_state != ST_IDLE) || (w_count != '0);

endmodule
